reg_file_wb: RTL and testbench
==============================

// Module: reg_file_wb
// PURPOSE
//  Register file and write-back port for the SISC datapath, directly downstream of
//  the write-register-select mux. Its wr_sel input consumes that mux's 4-bit output.
//  - Stores the 16 general registers and provides two combinational read ports.
//  - Commits one write per clock.
//  - Keeps a pending-write scoreboard. The scoreboard flags read-after-write hazards
//    to the control unit, which stalls on them.
// PARAMETERS
//  DATA_W  32              register width in bits
//  ADDR_W  4               register address width
//  NREGS   2**ADDR_W (16)  number of registers; R0 is hardwired to zero
// PORTS
//  clk       in   1       system clock; all state updates on the rising edge
//  rst       in   1       synchronous reset, active-high
//  rd_sel_a  in   ADDR_W  read port A register index
//  rd_sel_b  in   ADDR_W  read port B register index
//  wr_sel    in   ADDR_W  write register index (from the write-register-select mux)
//  wr_data   in   DATA_W  write-back data
//  rf_we     in   1       write enable; commits wr_data to wr_sel at the edge
//  resv_en   in   1       issue reservation: mark resv_sel as pending
//  resv_sel  in   ADDR_W  register index being reserved
//  rsa       out  DATA_W  read data, port A
//  rsb       out  DATA_W  read data, port B
//  hazard    out  1       1 = a source register has an outstanding write; stall
// BEHAVIOUR
//  - Reset: when rst=1 at an edge, all registers clear to 0 and all pending bits
//    clear to 0. rf_we and resv_en are ignored in that cycle. Outputs then settle
//    to rsa=rsb=0 and hazard=0.
//    If rst is asserted mid-sequence, any in-flight reservation is dropped.
//  - Write: if rf_we=1 and wr_sel!=0, reg[wr_sel]<=wr_data at the edge.
//    Writes to R0 are discarded silently.
//  - Read (combinational, zero latency):
//    - rsa = 0 if rd_sel_a==0.
//    - Otherwise rsa = wr_data if rf_we && wr_sel==rd_sel_a (same-cycle bypass).
//    - Otherwise rsa = reg[rd_sel_a].
//    - rsb follows the same rule using rd_sel_b.
//  - Scoreboard: one pending bit per register; bit 0 is constant 0.
//    - Set: resv_en=1 and resv_sel!=0 sets pending[resv_sel] at the edge.
//    - Clear: rf_we=1 clears pending[wr_sel] at the edge.
//    - Same register set and cleared in one cycle: the set wins. The register
//      stays pending because the new reservation belongs to a younger instruction.
//    - A write to a non-pending register is legal and leaves the bit at 0.
//  - hazard (combinational) = (pa | pb).
//    - pa = pending[rd_sel_a] && !(rf_we && wr_sel==rd_sel_a).
//    - pb is defined the same way for rd_sel_b.
//    - A register being written this cycle is covered by the bypass, so it is
//      not a hazard.
//  - Width rules: no arithmetic is performed. Indices are used unsigned and are
//    always in range because NREGS = 2**ADDR_W.
//  - Single write port: no write-write collision is possible. Reserving an
//    already-pending register is legal, and the bit stays 1.
// STRUCTURE
//  - Shared package (sisc_pkg):
//    - DATA_W and ADDR_W constants.
//    - Register-index type.
//    - R0 index constant.
//  - Sub-module rf_scoreboard holds the pending vector, the set/clear priority
//    logic and the hazard equation.
//  - The register array, the bypass muxes and the R0 forcing stay in reg_file_wb.
// TESTING
//  1. Reset clears state: preload R5=0x1234, hold rst=1 for one edge, then set
//     rd_sel_a=5 -> rsa=0 and hazard=0.
//  2. R0 is read-only zero: rf_we=1, wr_sel=0, wr_data=0xFFFFFFFF, then
//     rd_sel_a=0 -> rsa=0.
//  3. Write then read: write R3=0xDEADBEEF, then rd_sel_b=3 on the next cycle
//     -> rsb=0xDEADBEEF.
//  4. Same-cycle bypass: in one cycle set rf_we=1, wr_sel=7, wr_data=0xA5A5A5A5
//     and rd_sel_a=7 -> rsa=0xA5A5A5A5 in that same cycle, with hazard=0.
//  5. Reserve then retire:
//     - resv_en=1, resv_sel=4 -> next cycle rd_sel_a=4 gives hazard=1.
//     - hazard stays 1 through idle cycles.
//     - Write R4 -> hazard=0 during the write cycle and after it.
//  6. Set/clear race: R9 is pending; in one cycle set rf_we=1, wr_sel=9,
//     resv_en=1, resv_sel=9 -> next cycle rd_sel_b=9 gives hazard=1 and
//     rsb=the newly written data.

Source files
------------

// File: rtl/sisc_pkg.sv
// Shared constants and types for the SISC datapath.
//   SISC_DATA_W : register width in bits
//   SISC_ADDR_W : register address width
//   reg_idx_t   : register index type
//   R0          : index of the hardwired-zero register
package sisc_pkg;

  localparam int unsigned SISC_DATA_W = 32;
  localparam int unsigned SISC_ADDR_W = 4;

  typedef logic [SISC_ADDR_W-1:0] reg_idx_t;

  localparam reg_idx_t R0 = '0;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for the register file.
// One pending bit per register (bit 0 constant 0). A reservation sets a bit, a
// write-back clears it; a simultaneous set and clear of the same bit leaves it set.
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   i_resv_en/sel   : issue reservation of a destination register
//   i_wr_en/sel     : write-back retiring a register
//   i_rd_sel_a/b    : source register indices
//   o_hazard        : a source has an outstanding write not covered by bypass
module rf_scoreboard
  import sisc_pkg::*;
#(
  parameter int unsigned ADDR_W = SISC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_resv_en,
  input  logic [ADDR_W-1:0] i_resv_sel,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_wr_sel,
  input  logic [ADDR_W-1:0] i_rd_sel_a,
  input  logic [ADDR_W-1:0] i_rd_sel_b,
  output logic              o_hazard
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [NREGS-1:0] r_pending;
  logic [NREGS-1:0] w_pending_d;
  logic             w_pa;
  logic             w_pb;

  always_comb begin
    w_pending_d = r_pending;
    if (i_wr_en) begin
      w_pending_d[i_wr_sel] = 1'b0;
    end
    // Applied after the clear: a new reservation belongs to a younger instruction.
    if (i_resv_en && (i_resv_sel != ADDR_W'(R0))) begin
      w_pending_d[i_resv_sel] = 1'b1;
    end
    w_pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_d;
    end
  end

  // A source being written this cycle is served by the bypass, so it never stalls.
  always_comb begin
    w_pa     = r_pending[i_rd_sel_a] && !(i_wr_en && (i_wr_sel == i_rd_sel_a));
    w_pb     = r_pending[i_rd_sel_b] && !(i_wr_en && (i_wr_sel == i_rd_sel_b));
    o_hazard = w_pa | w_pb;
  end

endmodule

// File: rtl/reg_file_wb.sv
// SISC register file with write-back port and pending-write scoreboard.
// 16 general registers (R0 hardwired to zero), two combinational read ports with
// same-cycle write bypass, one write per clock.
// Ports:
//   clk, rst           : clock, synchronous active-high reset
//   rd_sel_a, rd_sel_b : read port indices
//   wr_sel, wr_data    : write-back index and data, committed when rf_we=1
//   resv_en, resv_sel  : mark a register as pending at issue
//   rsa, rsb           : read data
//   hazard             : stall request, a source register is still pending
module reg_file_wb
  import sisc_pkg::*;
#(
  parameter int unsigned DATA_W = SISC_DATA_W,
  parameter int unsigned ADDR_W = SISC_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_sel_a,
  input  logic [ADDR_W-1:0] rd_sel_b,
  input  logic [ADDR_W-1:0] wr_sel,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rf_we,
  input  logic              resv_en,
  input  logic [ADDR_W-1:0] resv_sel,
  output logic [DATA_W-1:0] rsa,
  output logic [DATA_W-1:0] rsb,
  output logic              hazard
);

  localparam int unsigned NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_regs [NREGS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (rf_we && (wr_sel != ADDR_W'(R0))) begin
      r_regs[wr_sel] <= wr_data;
    end
  end

  always_comb begin
    rsa = r_regs[rd_sel_a];
    if (rd_sel_a == ADDR_W'(R0)) begin
      rsa = '0;
    end else if (rf_we && (wr_sel == rd_sel_a)) begin
      rsa = wr_data;
    end

    rsb = r_regs[rd_sel_b];
    if (rd_sel_b == ADDR_W'(R0)) begin
      rsb = '0;
    end else if (rf_we && (wr_sel == rd_sel_b)) begin
      rsb = wr_data;
    end
  end

  rf_scoreboard #(
    .ADDR_W(ADDR_W)
  ) u_scoreboard (
    .clk       (clk),
    .rst       (rst),
    .i_resv_en (resv_en),
    .i_resv_sel(resv_sel),
    .i_wr_en   (rf_we),
    .i_wr_sel  (wr_sel),
    .i_rd_sel_a(rd_sel_a),
    .i_rd_sel_b(rd_sel_b),
    .o_hazard  (hazard)
  );

endmodule

// File: tb/tb_reg_file_wb.sv
// Directed self-checking bench for reg_file_wb.
module tb_reg_file_wb;

  logic        clk;
  logic        rst;
  logic [3:0]  rd_sel_a;
  logic [3:0]  rd_sel_b;
  logic [3:0]  wr_sel;
  logic [31:0] wr_data;
  logic        rf_we;
  logic        resv_en;
  logic [3:0]  resv_sel;
  logic [31:0] rsa;
  logic [31:0] rsb;
  logic        hazard;

  int n_total = 0;
  int n_pass  = 0;

  reg_file_wb u_dut (
    .clk     (clk),
    .rst     (rst),
    .rd_sel_a(rd_sel_a),
    .rd_sel_b(rd_sel_b),
    .wr_sel  (wr_sel),
    .wr_data (wr_data),
    .rf_we   (rf_we),
    .resv_en (resv_en),
    .resv_sel(resv_sel),
    .rsa     (rsa),
    .rsb     (rsb),
    .hazard  (hazard)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled mid-cycle.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rf_we    = 1'b0;
    wr_sel   = 4'd0;
    wr_data  = 32'd0;
    resv_en  = 1'b0;
    resv_sel = 4'd0;
  endtask

  initial begin
    rst      = 1'b1;
    rd_sel_a = 4'd0;
    rd_sel_b = 4'd0;
    idle_inputs();
    step();
    step();
    rst = 1'b0;
    #1;
    check("reset_rsa", rsa, 32'd0);
    check("reset_hazard", 32'(hazard), 32'd0);

    // Test 1: preload R5, reserve R6, then reset with write/reserve requests present.
    rf_we = 1'b1; wr_sel = 4'd5; wr_data = 32'h0000_1234;
    resv_en = 1'b1; resv_sel = 4'd6;
    step();
    idle_inputs();
    rd_sel_a = 4'd5; rd_sel_b = 4'd6;
    #1;
    check("preload_r5", rsa, 32'h0000_1234);
    check("preload_r6_pending", 32'(hazard), 32'd1);
    rst = 1'b1;
    rf_we = 1'b1; wr_sel = 4'd5; wr_data = 32'h5555_5555;
    resv_en = 1'b1; resv_sel = 4'd8;
    step();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rst_clears_r5", rsa, 32'd0);
    check("rst_drops_resv", 32'(hazard), 32'd0);
    rd_sel_b = 4'd8;
    #1;
    check("rst_ignores_resv", 32'(hazard), 32'd0);

    // Test 2: R0 is read-only zero, including the bypass path.
    rf_we = 1'b1; wr_sel = 4'd0; wr_data = 32'hFFFF_FFFF;
    rd_sel_a = 4'd0; rd_sel_b = 4'd0;
    resv_en = 1'b1; resv_sel = 4'd0;
    #1;
    check("r0_no_bypass", rsa, 32'd0);
    step();
    idle_inputs();
    #1;
    check("r0_after_write", rsa, 32'd0);
    check("r0_never_pending", 32'(hazard), 32'd0);

    // Test 3: write then read on port B.
    rf_we = 1'b1; wr_sel = 4'd3; wr_data = 32'hDEAD_BEEF;
    step();
    idle_inputs();
    rd_sel_b = 4'd3;
    #1;
    check("wr_rd_r3", rsb, 32'hDEAD_BEEF);

    // Test 4: same-cycle bypass onto a pending register.
    resv_en = 1'b1; resv_sel = 4'd7;
    step();
    idle_inputs();
    rd_sel_a = 4'd7; rd_sel_b = 4'd3;
    #1;
    check("r7_pending", 32'(hazard), 32'd1);
    rf_we = 1'b1; wr_sel = 4'd7; wr_data = 32'hA5A5_A5A5;
    #1;
    check("bypass_rsa", rsa, 32'hA5A5_A5A5);
    check("bypass_rsb_untouched", rsb, 32'hDEAD_BEEF);
    check("bypass_no_hazard", 32'(hazard), 32'd0);
    step();
    idle_inputs();
    #1;
    check("r7_stored", rsa, 32'hA5A5_A5A5);
    check("r7_retired", 32'(hazard), 32'd0);

    // Test 5: reserve then retire R4.
    resv_en = 1'b1; resv_sel = 4'd4;
    step();
    idle_inputs();
    rd_sel_a = 4'd4; rd_sel_b = 4'd0;
    #1;
    check("r4_hazard", 32'(hazard), 32'd1);
    step();
    step();
    check("r4_hazard_idle", 32'(hazard), 32'd1);
    rf_we = 1'b1; wr_sel = 4'd4; wr_data = 32'h0000_0044;
    #1;
    check("r4_write_cycle", 32'(hazard), 32'd0);
    step();
    idle_inputs();
    #1;
    check("r4_after_write", 32'(hazard), 32'd0);
    check("r4_data", rsa, 32'h0000_0044);

    // Test 6: set/clear race on R9, hazard seen through port B.
    resv_en = 1'b1; resv_sel = 4'd9;
    step();
    rf_we = 1'b1; wr_sel = 4'd9; wr_data = 32'h9999_0009;
    resv_en = 1'b1; resv_sel = 4'd9;
    step();
    idle_inputs();
    rd_sel_a = 4'd3; rd_sel_b = 4'd9;
    #1;
    check("race_hazard", 32'(hazard), 32'd1);
    check("race_rsb", rsb, 32'h9999_0009);

    // Bypass on port B, and writing a non-pending register leaves it clear.
    rf_we = 1'b1; wr_sel = 4'd10; wr_data = 32'h0A0A_0A0A;
    rd_sel_a = 4'd0; rd_sel_b = 4'd10;
    #1;
    check("bypass_rsb", rsb, 32'h0A0A_0A0A);
    step();
    idle_inputs();
    #1;
    check("nonpending_write", 32'(hazard), 32'd0);

    // Re-reserving an already-pending register keeps it pending.
    resv_en = 1'b1; resv_sel = 4'd9;
    step();
    idle_inputs();
    rd_sel_a = 4'd9; rd_sel_b = 4'd0;
    #1;
    check("rereserve", 32'(hazard), 32'd1);

    // Mid-sequence reset drops R9's reservation and clears R3.
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd_sel_b = 4'd3;
    #1;
    check("midrst_hazard", 32'(hazard), 32'd0);
    check("midrst_r3", rsb, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
